// File: rtl/aplic_latency_counter_bank_pkg.sv
// Shared types and default sizes for the APLIC latency counter bank.
package aplic_counter_pkg;

   typedef enum logic [1:0] {
      CNT_IDLE = 2'd0,
      CNT_RUN  = 2'd1,
      CNT_DONE = 2'd2
   } cnt_state_e;

   localparam int unsigned NUM_CH_DEF = 4;
   localparam int unsigned CNT_W_DEF  = 32;

endpackage

// File: rtl/aplic_latency_counter_bank_if.sv
// Start/stop/clear controls and packed per-channel results of the counter bank.
interface aplic_latency_counter_bank_if
   import aplic_counter_pkg::*;
#(
   parameter int unsigned NUM_CH = NUM_CH_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) ();

   logic [NUM_CH-1:0]       start_i;
   logic [NUM_CH-1:0]       stop_i;
   logic [NUM_CH-1:0]       clear_i;
   logic [NUM_CH*CNT_W-1:0] count_o;
   logic [NUM_CH*CNT_W-1:0] last_o;
   logic [NUM_CH*CNT_W-1:0] max_o;
   logic [NUM_CH-1:0]       busy_o;
   logic [NUM_CH-1:0]       done_o;
   logic [NUM_CH-1:0]       ovf_o;

   // Measurement requester: drives the events, observes the results.
   modport master (
      output start_i, stop_i, clear_i,
      input  count_o, last_o, max_o, busy_o, done_o, ovf_o
   );

   // Counter bank side.
   modport slave (
      input  start_i, stop_i, clear_i,
      output count_o, last_o, max_o, busy_o, done_o, ovf_o
   );

endinterface

// File: rtl/aplic_latency_counter_bank_ch.sv
// One latency channel: start/stop edge detectors, IDLE/RUN/DONE FSM,
// live counter, last/max results and sticky overflow.
module aplic_latency_counter_ch
   import aplic_counter_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned SATURATE  = 1,
   parameter int unsigned TRACK_MAX = 1
) (
   input  logic             clk_i,
   input  logic             rst_sys_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] count_o,
   output logic [CNT_W-1:0] last_o,
   output logic [CNT_W-1:0] max_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             ovf_o
);

   cnt_state_e       state_q;
   logic             start_q, stop_q;
   logic             start_rise, stop_rise;
   logic [CNT_W-1:0] count_q, last_q, max_q;
   logic [CNT_W-1:0] count_d;
   logic             wrap_d;
   logic             ovf_q, done_q;

   // Rising-edge events and the next counter value (saturating or wrapping).
   always_comb begin
      start_rise = start_i & ~start_q;
      stop_rise  = stop_i & ~stop_q;
      wrap_d     = &count_q;
      if (!wrap_d) begin
         count_d = count_q + 1'b1;
      end else if (SATURATE != 0) begin
         count_d = '1;
      end else begin
         count_d = '0;
      end
   end

   // Edge-detector history, sampled every cycle including during clear.
   always_ff @(posedge clk_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         start_q <= start_i;
         stop_q  <= stop_i;
      end
   end

   // Measurement FSM with registered results; clear overrides any event.
   always_ff @(posedge clk_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         state_q <= CNT_IDLE;
         count_q <= '0;
         last_q  <= '0;
         max_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else if (clear_i) begin
         state_q <= CNT_IDLE;
         count_q <= '0;
         last_q  <= '0;
         max_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            CNT_IDLE, CNT_DONE: begin
               if (start_rise) begin
                  state_q <= CNT_RUN;
                  count_q <= '0;
               end
            end
            CNT_RUN: begin
               count_q <= count_d;
               if (wrap_d) begin
                  ovf_q <= 1'b1;
               end
               if (stop_rise) begin
                  state_q <= CNT_DONE;
                  last_q  <= count_d;
                  done_q  <= 1'b1;
                  if ((TRACK_MAX != 0) && (count_d > max_q)) begin
                     max_q <= count_d;
                  end
               end
            end
            default: state_q <= CNT_IDLE;
         endcase
      end
   end

   assign count_o = count_q;
   assign last_o  = last_q;
   assign max_o   = max_q;
   assign busy_o  = (state_q == CNT_RUN);
   assign done_o  = done_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/aplic_latency_counter_bank.sv
// Bank of NUM_CH independent latency channels; wiring and output packing only.
module aplic_latency_counter_bank
   import aplic_counter_pkg::*;
#(
   parameter int unsigned NUM_CH    = NUM_CH_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned SATURATE  = 1,
   parameter int unsigned TRACK_MAX = 1
) (
   input  logic                         clk_i,
   input  logic                         rst_sys_ni,
   aplic_latency_counter_bank_if.slave  bus_if
);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      aplic_latency_counter_ch #(
         .CNT_W     (CNT_W),
         .SATURATE  (SATURATE),
         .TRACK_MAX (TRACK_MAX)
      ) u_ch (
         .clk_i      (clk_i),
         .rst_sys_ni (rst_sys_ni),
         .start_i    (bus_if.start_i[c]),
         .stop_i     (bus_if.stop_i[c]),
         .clear_i    (bus_if.clear_i[c]),
         .count_o    (bus_if.count_o[c*CNT_W +: CNT_W]),
         .last_o     (bus_if.last_o[c*CNT_W +: CNT_W]),
         .max_o      (bus_if.max_o[c*CNT_W +: CNT_W]),
         .busy_o     (bus_if.busy_o[c]),
         .done_o     (bus_if.done_o[c]),
         .ovf_o      (bus_if.ovf_o[c])
      );
   end

endmodule

// File: tb/tb_aplic_latency_counter_bank.sv
// Scoreboard bench: a cycle-stamp reference model pushes expected results
// per channel, a negedge monitor pops them on done_o and tracks busy/count.
module tb_aplic_latency_counter_bank;

   localparam int NCH = 4;
   localparam int W   = 32;

   typedef struct {
      logic [63:0] last;
      logic [63:0] max;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   aplic_latency_counter_bank_if #(.NUM_CH(NCH), .CNT_W(W)) bus ();
   aplic_latency_counter_bank_if #(.NUM_CH(1), .CNT_W(8)) b8s ();
   aplic_latency_counter_bank_if #(.NUM_CH(1), .CNT_W(8)) b8w ();

   aplic_latency_counter_bank #(.NUM_CH(NCH), .CNT_W(W), .SATURATE(1), .TRACK_MAX(1)) u_dut (
      .clk_i(clk), .rst_sys_ni(rst_n), .bus_if(bus));
   aplic_latency_counter_bank #(.NUM_CH(1), .CNT_W(8), .SATURATE(1), .TRACK_MAX(1)) u_dut8s (
      .clk_i(clk), .rst_sys_ni(rst_n), .bus_if(b8s));
   aplic_latency_counter_bank #(.NUM_CH(1), .CNT_W(8), .SATURATE(0), .TRACK_MAX(1)) u_dut8w (
      .clk_i(clk), .rst_sys_ni(rst_n), .bus_if(b8w));

   logic st8, sp8;
   assign b8s.start_i = st8;
   assign b8s.stop_i  = sp8;
   assign b8s.clear_i = 1'b0;
   assign b8w.start_i = st8;
   assign b8w.stop_i  = sp8;
   assign b8w.clear_i = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   // reference model: per-channel measurement described by cycle stamps
   int          cyc = 0;
   bit          m_run   [NCH];
   int          m_start [NCH];
   logic [63:0] m_frozen[NCH];
   logic [63:0] m_last  [NCH];
   logic [63:0] m_max   [NCH];
   bit          m_ovf   [NCH];
   logic [NCH-1:0] m_ps, m_pp;
   exp_t        q[NCH][$];
   bit          exp_busy [NCH];
   logic [63:0] exp_count[NCH];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_run[c] = 0; m_start[c] = 0; m_frozen[c] = 0;
         m_last[c] = 0; m_max[c] = 0; m_ovf[c] = 0;
         exp_busy[c] = 0; exp_count[c] = 0;
         q[c].delete();
      end
      m_ps = '0; m_pp = '0;
   endtask

   // One clock cycle of stimulus on the main bank plus the model's view of it.
   task automatic step(input logic [NCH-1:0] s, input logic [NCH-1:0] p, input logic [NCH-1:0] cl);
      longint lat;
      exp_t   e;
      for (int c = 0; c < NCH; c++) begin
         exp_busy[c]  = m_run[c];
         exp_count[c] = m_run[c] ? 64'(cyc - m_start[c] - 1) : m_frozen[c];
      end
      bus.start_i = s;
      bus.stop_i  = p;
      bus.clear_i = cl;
      for (int c = 0; c < NCH; c++) begin
         if (cl[c]) begin
            m_run[c] = 0; m_frozen[c] = 0; m_last[c] = 0; m_max[c] = 0; m_ovf[c] = 0;
         end else if (m_run[c]) begin
            if (p[c] && !m_pp[c]) begin
               lat = longint'(cyc - m_start[c]);
               if (lat > 64'hFFFF_FFFF) begin
                  m_ovf[c] = 1;
                  lat = 64'hFFFF_FFFF;
               end
               m_last[c]   = 64'(lat);
               m_frozen[c] = 64'(lat);
               if (m_last[c] > m_max[c]) m_max[c] = m_last[c];
               m_run[c] = 0;
               e.last = m_last[c]; e.max = m_max[c]; e.ovf = m_ovf[c];
               q[c].push_back(e);
            end
         end else if (s[c] && !m_ps[c]) begin
            m_run[c]   = 1;
            m_start[c] = cyc;
         end
      end
      m_ps = s;
      m_pp = p;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Monitor: live busy/count every cycle, result check on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         for (int c = 0; c < NCH; c++) begin
            chk($sformatf("busy ch%0d", c), 64'(bus.busy_o[c]), 64'(exp_busy[c]));
            chk($sformatf("count ch%0d", c), 64'(bus.count_o[c*W +: W]), exp_count[c]);
            if (bus.done_o[c]) begin
               if (q[c].size() == 0) begin
                  chk($sformatf("unexpected done ch%0d", c), 64'd1, 64'd0);
               end else begin
                  e = q[c].pop_front();
                  chk($sformatf("last ch%0d", c), 64'(bus.last_o[c*W +: W]), e.last);
                  chk($sformatf("max ch%0d", c), 64'(bus.max_o[c*W +: W]), e.max);
                  chk($sformatf("ovf ch%0d", c), 64'(bus.ovf_o[c]), 64'(e.ovf));
               end
            end
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, " count"}, 64'(|bus.count_o), 64'd0);
      chk({tag, " last"},  64'(|bus.last_o),  64'd0);
      chk({tag, " max"},   64'(|bus.max_o),   64'd0);
      chk({tag, " busy"},  64'(bus.busy_o),   64'd0);
      chk({tag, " done"},  64'(bus.done_o),   64'd0);
      chk({tag, " ovf"},   64'(bus.ovf_o),    64'd0);
      chk({tag, " 8b last"}, 64'(b8s.last_o | b8w.last_o), 64'd0);
      chk({tag, " 8b ovf"},  64'(b8s.ovf_o | b8w.ovf_o),   64'd0);
   endtask

   task automatic run0(input int len, input logic [63:0] exp_last, input logic [63:0] exp_max);
      step(4'h1, 4'h0, 4'h0);
      repeat (len - 1) step(4'h1, 4'h0, 4'h0);
      step(4'h1, 4'h1, 4'h0);
      chk("maxseq done", 64'(bus.done_o[0]), 64'd1);
      chk("maxseq last", 64'(bus.last_o[W-1:0]), exp_last);
      chk("maxseq max",  64'(bus.max_o[W-1:0]),  exp_max);
      step(4'h0, 4'h0, 4'h0);
   endtask

   initial begin
      logic [NCH-1:0] ls, lp, lc, pv;
      rst_n = 1'b0;
      bus.start_i = '0; bus.stop_i = '0; bus.clear_i = '0;
      st8 = 1'b0; sp8 = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      repeat (3) step(4'h0, 4'h0, 4'h0);

      // basic: stop rise 5 cycles after start rise
      step(4'h1, 4'h0, 4'h0);
      repeat (4) step(4'h1, 4'h0, 4'h0);
      step(4'h1, 4'h1, 4'h0);
      chk("basic done", 64'(bus.done_o[0]), 64'd1);
      chk("basic last", 64'(bus.last_o[W-1:0]), 64'd5);
      chk("basic busy", 64'(bus.busy_o[0]), 64'd0);
      step(4'h0, 4'h0, 4'h0);
      chk("basic done pulse width", 64'(bus.done_o[0]), 64'd0);

      // simultaneous start+stop rise from DONE: start wins
      step(4'h1, 4'h1, 4'h0);
      chk("simul busy", 64'(bus.busy_o[0]), 64'd1);
      repeat (6) step(4'h1, 4'h0, 4'h0);
      step(4'h1, 4'h1, 4'h0);
      chk("simul last", 64'(bus.last_o[W-1:0]), 64'd7);
      step(4'h0, 4'h0, 4'h0);

      // max tracking after a clear
      step(4'h0, 4'h0, 4'h1);
      run0(20, 64'd20, 64'd20);
      run0(5,  64'd5,  64'd20);
      run0(30, 64'd30, 64'd30);

      // clear overrides a same-cycle stop rise
      step(4'h1, 4'h0, 4'h0);
      repeat (4) step(4'h1, 4'h0, 4'h0);
      step(4'h1, 4'h1, 4'h1);
      chk("clear done",  64'(bus.done_o[0]), 64'd0);
      chk("clear count", 64'(bus.count_o[W-1:0]), 64'd0);
      chk("clear last",  64'(bus.last_o[W-1:0]), 64'd0);
      chk("clear max",   64'(bus.max_o[W-1:0]), 64'd0);
      chk("clear ovf",   64'(bus.ovf_o[0]), 64'd0);
      chk("clear busy",  64'(bus.busy_o[0]), 64'd0);
      step(4'h0, 4'h0, 4'h0);

      // independent overlapping runs
      step(4'hF, 4'h0, 4'h0);
      for (int t = 1; t <= 40; t++) begin
         pv = {(t >= 40), (t >= 17), (t >= 9), (t >= 3)};
         step(4'hF, pv, 4'h0);
      end
      chk("indep last0", 64'(bus.last_o[0*W +: W]), 64'd3);
      chk("indep last1", 64'(bus.last_o[1*W +: W]), 64'd9);
      chk("indep last2", 64'(bus.last_o[2*W +: W]), 64'd17);
      chk("indep last3", 64'(bus.last_o[3*W +: W]), 64'd40);
      step(4'h0, 4'h0, 4'h0);

      // 8-bit overflow: 300-cycle run on saturating and wrapping banks
      st8 = 1'b1;
      step(4'h0, 4'h0, 4'h0);
      repeat (299) step(4'h0, 4'h0, 4'h0);
      sp8 = 1'b1;
      step(4'h0, 4'h0, 4'h0);
      chk("sat done", 64'(b8s.done_o), 64'd1);
      chk("sat last", 64'(b8s.last_o), 64'd255);
      chk("sat ovf",  64'(b8s.ovf_o),  64'd1);
      chk("wrap done", 64'(b8w.done_o), 64'd1);
      chk("wrap last", 64'(b8w.last_o), 64'd44);
      chk("wrap ovf",  64'(b8w.ovf_o),  64'd1);
      st8 = 1'b0; sp8 = 1'b0;
      step(4'h0, 4'h0, 4'h0);

      // randomized levels on all channels
      ls = '0; lp = '0;
      for (int i = 0; i < 1500; i++) begin
         lc = '0;
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 7) == 0)  ls[c] = ~ls[c];
            if ($urandom_range(0, 7) == 0)  lp[c] = ~lp[c];
            if ($urandom_range(0, 63) == 0) lc[c] = 1'b1;
         end
         step(ls, lp, lc);
      end
      step(4'h0, 4'h0, 4'h0);
      step(4'h0, 4'h0, 4'h0);

      // async reset in the middle of a measurement
      step(4'hF, 4'h0, 4'h0);
      repeat (10) step(4'hF, 4'h0, 4'h0);
      mon_en = 1'b0;
      #2;
      rst_n = 1'b0;
      bus.start_i = '0;
      #1;
      chk_all_zero("async reset");
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      repeat (4) step(4'h0, 4'h0, 4'h0);
      chk_all_zero("after reset");

      for (int c = 0; c < NCH; c++)
         chk($sformatf("pending results ch%0d", c), 64'(q[c].size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
